// File: rtl/weight_stream_ctrl.sv
// Weight fetch sequencer: streams a per-job run of words from NUM_CH BRAM banks
// into the systolic array weight lanes, with optional diagonal skew across lanes.
module weight_stream_ctrl #(
  parameter int NUM_CH  = 16,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 6,
  parameter int SKEW_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [ADDR_W-1:0]          base_addr_i,
  input  logic [LEN_W-1:0]           len_i,
  input  logic [NUM_CH-1:0]          ch_mask_i,
  input  logic                       abort_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [NUM_CH-1:0]          bram_en_o,
  output logic [NUM_CH*ADDR_W-1:0]   bram_addr_o,
  input  logic [NUM_CH*DATA_W-1:0]   bram_rdata_i,
  output logic [NUM_CH*DATA_W-1:0]   w_data_o,
  output logic [NUM_CH-1:0]          w_valid_o
);

  localparam int CW = LEN_W + $clog2(NUM_CH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                drain_ph, drain_ph_nxt;
  logic [ADDR_W-1:0]   base_q;
  logic [LEN_W-1:0]    len_q;
  logic [NUM_CH-1:0]   mask_q;
  logic [CW-1:0]       last_cnt;
  logic                accept;
  logic                flush;

  logic [ADDR_W-1:0]   base_sel;
  logic [LEN_W-1:0]    len_sel;
  logic [NUM_CH-1:0]   mask_sel;
  logic [NUM_CH-1:0]   en_nxt;
  logic [NUM_CH*ADDR_W-1:0] addr_nxt;
  logic                done_nxt;
  logic [NUM_CH-1:0]   en_d1;

  assign accept   = (state == IDLE) && start_i && (len_i != '0);
  assign flush    = abort_i && (state != IDLE);
  assign last_cnt = CW'(len_q) + CW'((SKEW_EN != 0) ? NUM_CH - 1 : 0) - CW'(1);

  // The first issue slot is computed on the accept edge, so config comes from the inputs then.
  assign base_sel = accept ? base_addr_i : base_q;
  assign len_sel  = accept ? len_i       : len_q;
  assign mask_sel = accept ? ch_mask_i   : mask_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      drain_ph <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      mask_q   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      drain_ph <= drain_ph_nxt;
      if (accept) begin
        base_q <= base_addr_i;
        len_q  <= len_i;
        mask_q <= ch_mask_i;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    drain_ph_nxt = drain_ph;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (cnt == last_cnt) begin
          state_nxt    = DRAIN;
          drain_ph_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DRAIN: begin
        if (abort_i || drain_ph) begin
          state_nxt = IDLE;
        end else begin
          drain_ph_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    logic [CW-1:0] lane_off;
    logic [CW-1:0] lane_o;
    en_nxt   = '0;
    addr_nxt = bram_addr_o;
    for (int i = 0; i < NUM_CH; i++) begin
      lane_off = (SKEW_EN != 0) ? CW'(i) : '0;
      lane_o   = cnt_nxt - lane_off;
      if ((state_nxt == RUN) && mask_sel[i] && (cnt_nxt >= lane_off) &&
          (lane_o < CW'(len_sel))) begin
        en_nxt[i] = 1'b1;
        addr_nxt[i*ADDR_W +: ADDR_W] = base_sel + ADDR_W'(lane_o);
      end
    end
    done_nxt = ((state == IDLE) && start_i && (len_i == '0)) ||
               ((state == DRAIN) && !drain_ph && !abort_i);
  end

  // Two-stage read pipeline: enable -> BRAM data -> SA lane.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      bram_en_o   <= '0;
      bram_addr_o <= '0;
      en_d1       <= '0;
      w_valid_o   <= '0;
      w_data_o    <= '0;
    end else begin
      busy_o      <= (state_nxt != IDLE);
      done_o      <= done_nxt;
      bram_en_o   <= en_nxt;
      bram_addr_o <= addr_nxt;
      if (flush) begin
        en_d1     <= '0;
        w_valid_o <= '0;
        w_data_o  <= '0;
      end else begin
        en_d1     <= bram_en_o;
        w_valid_o <= en_d1;
        for (int i = 0; i < NUM_CH; i++) begin
          w_data_o[i*DATA_W +: DATA_W] <= en_d1[i] ? bram_rdata_i[i*DATA_W +: DATA_W] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Bench for weight_stream_ctrl: aligned and skewed instances share stimulus and are
// compared every cycle against a job-timeline model, plus literal checks per scenario.
module tb_weight_stream_ctrl;

  localparam int NUM_CH = 16;
  localparam int AW     = 6;
  localparam int DW     = 8;
  localparam int LW     = 6;

  logic clk, rst_n, start, abort;
  logic [AW-1:0]     base;
  logic [LW-1:0]     len;
  logic [NUM_CH-1:0] mask;

  logic                   busy  [2];
  logic                   done  [2];
  logic [NUM_CH-1:0]      en    [2];
  logic [NUM_CH*AW-1:0]   addr  [2];
  logic [NUM_CH*DW-1:0]   rdata [2];
  logic [NUM_CH*DW-1:0]   wdata [2];
  logic [NUM_CH-1:0]      valid [2];

  weight_stream_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .SKEW_EN(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base), .len_i(len),
    .ch_mask_i(mask), .abort_i(abort), .busy_o(busy[0]), .done_o(done[0]),
    .bram_en_o(en[0]), .bram_addr_o(addr[0]), .bram_rdata_i(rdata[0]),
    .w_data_o(wdata[0]), .w_valid_o(valid[0]));

  weight_stream_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .SKEW_EN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base), .len_i(len),
    .ch_mask_i(mask), .abort_i(abort), .busy_o(busy[1]), .done_o(done[1]),
    .bram_en_o(en[1]), .bram_addr_o(addr[1]), .bram_rdata_i(rdata[1]),
    .w_data_o(wdata[1]), .w_valid_o(valid[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] wgt(input int i, input int a);
    return DW'((i * 37) ^ (a * 5) ^ 8'h5a);
  endfunction

  // Bank model: 1-cycle read latency, garbage on non-enabled lanes.
  function automatic logic [NUM_CH*DW-1:0] bank(input int s);
    logic [NUM_CH*DW-1:0] v;
    for (int i = 0; i < NUM_CH; i++)
      v[i*DW +: DW] = en[s][i] ? wgt(i, int'(addr[s][i*AW +: AW])) : DW'($urandom);
    return v;
  endfunction

  always @(posedge clk) begin
    rdata[0] <= bank(0);
    rdata[1] <= bank(1);
  end

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input int s, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h want=%h", nm, s, a, e);
    end
  endtask

  task automatic chkv(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, a, e);
    end
  endtask

  // Model: each accepted job is a timeline indexed by t = cycles since the accept edge.
  bit                  m_act  [2];
  int                  m_t    [2];
  int                  m_len  [2];
  logic [AW-1:0]       m_base [2];
  logic [NUM_CH-1:0]   m_mask [2];
  logic                e_busy [2];
  logic                e_done [2];
  logic [NUM_CH-1:0]   e_en   [2];
  logic [NUM_CH*AW-1:0] e_addr [2];
  logic [NUM_CH-1:0]   e_valid[2];
  logic [NUM_CH*DW-1:0] e_data [2];

  function automatic bit lane_on(input int s, input int i, input int c);
    int o;
    o = c - (s != 0 ? i : 0);
    return m_mask[s][i] && (o >= 0) && (o < m_len[s]);
  endfunction

  task automatic model_step();
    for (int s = 0; s < 2; s++) begin
      bit nullp;
      int last, off;
      nullp = 0;
      if (!rst_n) begin
        m_act[s] = 0; m_t[s] = 0; m_len[s] = 0; m_base[s] = '0; m_mask[s] = '0;
        e_addr[s] = '0;
        chk_on = 1;
      end else if (m_act[s]) begin
        if (abort) m_act[s] = 0;
        else m_t[s]++;
      end else if (start) begin
        if (len != 0) begin
          m_act[s] = 1; m_t[s] = 1;
          m_base[s] = base; m_len[s] = int'(len); m_mask[s] = mask;
        end else nullp = 1;
      end
      last = m_len[s] - 1 + (s != 0 ? NUM_CH - 1 : 0);
      if (m_act[s] && m_t[s] > last + 3) m_act[s] = 0;
      e_busy[s]  = m_act[s];
      e_done[s]  = nullp || (m_act[s] && m_t[s] == last + 3);
      e_en[s]    = '0;
      e_valid[s] = '0;
      e_data[s]  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        off = (s != 0) ? i : 0;
        if (m_act[s] && lane_on(s, i, m_t[s] - 1)) begin
          e_en[s][i] = 1'b1;
          e_addr[s][i*AW +: AW] = AW'(int'(m_base[s]) + m_t[s] - 1 - off);
        end
        if (m_act[s] && lane_on(s, i, m_t[s] - 3)) begin
          e_valid[s][i] = 1'b1;
          e_data[s][i*DW +: DW] = wgt(i, (int'(m_base[s]) + m_t[s] - 3 - off) & 63);
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (chk_on) begin
        for (int s = 0; s < 2; s++) begin
          chk("busy",  s, busy[s],  e_busy[s]);
          chk("done",  s, done[s],  e_done[s]);
          chk("en",    s, en[s],    e_en[s]);
          chk("addr",  s, addr[s],  e_addr[s]);
          chk("valid", s, valid[s], e_valid[s]);
          chk("wdata", s, wdata[s], e_data[s]);
        end
      end
    end
  end

  // Per-job observations of the DUT, sampled on the falling edge.
  int bcnt[2], dcnt[2], ecnt[2], vsum[2];
  int vcnt[2][NUM_CH];
  int n, last15;
  int aseq[$];

  task automatic cycle();
    @(negedge clk);
    n++;
    for (int s = 0; s < 2; s++) begin
      if (busy[s]) bcnt[s]++;
      if (done[s]) dcnt[s]++;
      ecnt[s] += $countones(en[s]);
      vsum[s] += $countones(valid[s]);
      for (int i = 0; i < NUM_CH; i++) if (valid[s][i]) vcnt[s][i]++;
    end
    if (en[0][0]) aseq.push_back(int'(addr[0][AW-1:0]));
    if (en[1][15]) last15 = n;
  endtask

  task automatic job(input int b, input int l, input int m, input int abort_at,
                     input int hold_n, input int rst_at);
    int k;
    for (int s = 0; s < 2; s++) begin
      bcnt[s] = 0; dcnt[s] = 0; ecnt[s] = 0; vsum[s] = 0;
      for (int i = 0; i < NUM_CH; i++) vcnt[s][i] = 0;
    end
    n = 0; last15 = 0; aseq.delete();
    base = AW'(b); len = LW'(l); mask = NUM_CH'(m); start = 1'b1;
    cycle();
    if (hold_n == 0) start = 1'b0;
    k = 1;
    while ((busy[0] || busy[1]) && k < 300) begin
      if (hold_n > 0 && k >= hold_n) start = 1'b0;
      if (k == abort_at) begin abort = 1'b1; start = 1'b0; end
      if (k == rst_at) rst_n = 1'b0;
      cycle();
      abort = 1'b0;
      rst_n = 1'b1;
      k++;
    end
    start = 1'b0;
    if (k >= 300) begin
      total++; bad++;
      $display("FAIL job_timeout got=busy want=idle");
    end
  endtask

  int wrap_exp [8] = '{60, 61, 62, 63, 0, 1, 2, 3};

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base = '0; len = '0; mask = '0;
    repeat (3) cycle();
    chk("rst_busy", 0, busy[0], 0);
    chk("rst_en",   1, en[1], 0);
    chk("rst_addr", 1, addr[1], 0);
    chk("rst_valid",0, valid[0], 0);
    rst_n = 1'b1;
    cycle();

    // Conv1-style
    job(0, 25, 'h003F, 0, 0, 0);
    chkv("conv1_busy0", bcnt[0], 27);
    chkv("conv1_done0", dcnt[0], 1);
    chkv("conv1_v0_lane0", vcnt[0][0], 25);
    chkv("conv1_v0_lane5", vcnt[0][5], 25);
    chkv("conv1_v0_lane6", vcnt[0][6], 0);
    chkv("conv1_busy1", bcnt[1], 42);

    // start held while busy is ignored
    job(7, 25, 'h003F, 0, 20, 0);
    chkv("hold_done0", dcnt[0], 1);
    chkv("hold_done1", dcnt[1], 1);

    // Conv2-style
    job(25, 26, 'hFFFF, 0, 0, 0);
    chkv("conv2_last15", last15, 41);
    chkv("conv2_done1", dcnt[1], 1);
    chkv("conv2_busy1", bcnt[1], 43);
    chkv("conv2_v1_lane15", vcnt[1][15], 26);

    // Wrap-around
    job(60, 8, 'h0001, 0, 0, 0);
    chkv("wrap_len", aseq.size(), 8);
    for (int i = 0; i < 8 && i < aseq.size(); i++) chkv("wrap_addr", aseq[i], wrap_exp[i]);

    // Abort on the 10th RUN cycle, then an immediate new job
    job(5, 30, 'hFFFF, 10, 0, 0);
    chkv("abort_busy0", bcnt[0], 10);
    chkv("abort_done0", dcnt[0] + dcnt[1], 0);
    chk("abort_en", 1, en[1], 0);
    chk("abort_valid", 1, valid[1], 0);
    job(40, 3, 'h0001, 0, 0, 0);
    chkv("post_abort_n", aseq.size(), 3);
    if (aseq.size() > 0) chkv("post_abort_addr0", aseq[0], 40);
    chkv("post_abort_done0", dcnt[0], 1);

    // Null and masked jobs
    job(0, 0, 'hFFFF, 0, 0, 0);
    chkv("null_done0", dcnt[0], 1);
    chkv("null_busy0", bcnt[0], 0);
    chkv("null_en0", ecnt[0], 0);
    job(3, 4, 'h0000, 0, 0, 0);
    chkv("mask0_busy0", bcnt[0], 6);
    chkv("mask0_done0", dcnt[0], 1);
    chkv("mask0_en0", ecnt[0] + vsum[0], 0);

    // Reset mid-DRAIN of the aligned instance
    job(0, 4, 'h000F, 0, 0, 5);
    chkv("rst_drain_done0", dcnt[0], 0);
    chk("rst_drain_en", 0, en[0], 0);
    chk("rst_drain_addr", 0, addr[0], 0);
    chk("rst_drain_valid", 0, valid[0], 0);
    chk("rst_drain_data", 0, wdata[0], 0);

    // Randomized jobs, back-to-back or with short gaps
    for (int j = 0; j < 30; j++) begin
      int l, m, ab, hd;
      l  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
      m  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 16'hFFFF));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
      hd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      job(int'($urandom_range(0, 63)), l, m, ab, hd, 0);
      repeat ($urandom_range(0, 2)) cycle();
    end

    repeat (3) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
